// File: rtl/sdf_r22_stage.sv
// One radix-2^2 single-path delay-feedback FFT stage: BF2I, BF2II with the
// trivial -j rotation, and a twiddle multiplier fed from an external ROM.
// State advances only on strobes, so gaps of any length are transparent.
module sdf_r22_stage #(
    parameter int M        = 64,
    parameter int WIDTH    = 8,
    parameter int TW_WIDTH = 10,
    parameter int SCALE    = 0,
    localparam int OW      = (SCALE != 0) ? WIDTH : WIDTH + 2,
    localparam int LG      = $clog2(M)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_in,
    input  logic [WIDTH-1:0]    in_re,
    input  logic [WIDTH-1:0]    in_im,
    output logic [LG-1:0]       tw_addr,
    input  logic [TW_WIDTH-1:0] tw_re,
    input  logic [TW_WIDTH-1:0] tw_im,
    output logic                enable_out,
    output logic [OW-1:0]       out_re,
    output logic [OW-1:0]       out_im
);

    localparam int W1 = WIDTH + 1;           // after BF2I
    localparam int W2 = WIDTH + 2;           // after BF2II
    localparam int ZW = WIDTH + 3;           // headroom for the rounding add
    localparam int PW = ZW + TW_WIDTH + 1;   // complex product width
    localparam int D1 = M / 2;
    localparam int D2 = M / 4;
    localparam int SH = TW_WIDTH - 2;

    localparam logic [LG-1:0]        PRIME_LAST = LG'(3 * M / 4 - 1);
    localparam logic [LG-1:0]        QUARTER    = LG'(M / 4);
    localparam logic [LG-1:0]        M_MASK     = LG'(M / 4 - 1);
    localparam logic signed [ZW-1:0] HALF_Z     = ZW'(2);
    localparam logic signed [PW-1:0] RND        = PW'(2 ** (TW_WIDTH - 3));
    localparam logic signed [PW-1:0] SAT_MAX    = PW'(2 ** (OW - 1) - 1);
    localparam logic signed [PW-1:0] SAT_MIN    = ~SAT_MAX;

    logic [LG-1:0] cnt_q;
    logic          primed_q;
    logic          enable_out_q;
    logic [OW-1:0] out_re_q, out_im_q;

    logic signed [W1-1:0] f1_re_q [D1];
    logic signed [W1-1:0] f1_im_q [D1];
    logic signed [W2-1:0] f2_re_q [D2];
    logic signed [W2-1:0] f2_im_q [D2];

    logic signed [W1-1:0] x_re, x_im, a_re, a_im, u_re, u_im, f1_re_d, f1_im_d;
    logic signed [W2-1:0] ue_re, ue_im, r_re, r_im, b_re, b_im;
    logic signed [W2-1:0] v_re, v_im, f2_re_d, f2_im_d;
    logic signed [ZW-1:0] ve_re, ve_im, z_re, z_im;
    logic signed [PW-1:0] zr_x, zi_x, c_x, d_x, prod_re, prod_im, rnd_re, rnd_im;
    logic [OW-1:0]        out_re_d, out_im_d;
    logic [LG-1:0]        pos, m_idx;
    logic [1:0]           k_idx;
    logic                 rot;

    function automatic logic [OW-1:0] sat_ow(input logic signed [PW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[OW-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[OW-1:0];
        end
        return v[OW-1:0];
    endfunction

    assign x_re = $signed(in_re);
    assign x_im = $signed(in_im);
    assign a_re = f1_re_q[D1-1];
    assign a_im = f1_im_q[D1-1];
    assign b_re = f2_re_q[D2-1];
    assign b_im = f2_im_q[D2-1];

    // BF2I: first half parks input and forwards stored differences; second half adds
    always_comb begin
        u_re    = a_re;
        u_im    = a_im;
        f1_re_d = x_re;
        f1_im_d = x_im;
        if (cnt_q[LG-1]) begin
            u_re    = a_re + x_re;
            u_im    = a_im + x_im;
            f1_re_d = a_re - x_re;
            f1_im_d = a_im - x_im;
        end
    end

    // -j on the second quarter of the BF2I difference half
    assign rot   = ~cnt_q[LG-1] & cnt_q[LG-2];
    assign ue_re = u_re;
    assign ue_im = u_im;
    assign r_re  = rot ? ue_im : ue_re;
    assign r_im  = rot ? -ue_re : ue_im;

    // BF2II: same park/forward vs add/subtract scheme at half the span
    always_comb begin
        v_re    = b_re;
        v_im    = b_im;
        f2_re_d = r_re;
        f2_im_d = r_im;
        if (cnt_q[LG-2]) begin
            v_re    = b_re + r_re;
            v_im    = b_im + r_im;
            f2_re_d = b_re - r_re;
            f2_im_d = b_im - r_im;
        end
    end

    // Optional divide-by-4 with round half up, ahead of the multiplier
    assign ve_re = v_re;
    assign ve_im = v_im;
    assign z_re  = (SCALE != 0) ? ((ve_re + HALF_Z) >>> 2) : ve_re;
    assign z_im  = (SCALE != 0) ? ((ve_im + HALF_Z) >>> 2) : ve_im;

    // Output position of the sample leaving BF2II is three quarters behind the counter
    assign pos     = cnt_q + QUARTER;
    assign m_idx   = pos & M_MASK;
    assign k_idx   = {pos[LG-2], pos[LG-1]};
    assign tw_addr = m_idx * LG'(k_idx);

    assign zr_x    = z_re;
    assign zi_x    = z_im;
    assign c_x     = $signed(tw_re);
    assign d_x     = $signed(tw_im);
    assign prod_re = zr_x * c_x - zi_x * d_x;
    assign prod_im = zr_x * d_x + zi_x * c_x;
    assign rnd_re  = (prod_re + RND) >>> SH;
    assign rnd_im  = (prod_im + RND) >>> SH;
    assign out_re_d = sat_ow(rnd_re);
    assign out_im_d = sat_ow(rnd_im);

    // Counter, priming flag and registered output
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            primed_q     <= 1'b0;
            enable_out_q <= 1'b0;
            out_re_q     <= '0;
            out_im_q     <= '0;
        end else begin
            enable_out_q <= enable_in & primed_q;
            if (enable_in) begin
                cnt_q <= cnt_q + LG'(1);
                if (cnt_q == PRIME_LAST) begin
                    primed_q <= 1'b1;
                end
                if (primed_q) begin
                    out_re_q <= out_re_d;
                    out_im_q <= out_im_d;
                end
            end
        end
    end

    // Feedback delay lines; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (enable_in) begin
            f1_re_q[0] <= f1_re_d;
            f1_im_q[0] <= f1_im_d;
            for (int i = 1; i < D1; i++) begin
                f1_re_q[i] <= f1_re_q[i-1];
                f1_im_q[i] <= f1_im_q[i-1];
            end
            f2_re_q[0] <= f2_re_d;
            f2_im_q[0] <= f2_im_d;
            for (int i = 1; i < D2; i++) begin
                f2_re_q[i] <= f2_re_q[i-1];
                f2_im_q[i] <= f2_im_q[i-1];
            end
        end
    end

    assign enable_out = enable_out_q;
    assign out_re     = out_re_q;
    assign out_im     = out_im_q;

endmodule

// File: tb/tb_sdf_r22_stage.sv
// Bench for sdf_r22_stage: three instances (M=16 growth, M=16 divide-by-4,
// M=4 growth) share one input stream; a direct four-point sum model feeds a
// per-instance scoreboard that is checked every cycle.
module tb_sdf_r22_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en;
    logic [7:0] in_re, in_im;
    logic [3:0] ta0, ta1;
    logic [1:0] ta2;
    logic [9:0] tr0, ti0, tr1, ti1, tr2, ti2;
    logic       eo0, eo1, eo2;
    logic [9:0] o0r, o0i, o2r, o2i;
    logic [7:0] o1r, o1i;

    logic signed [9:0] rom16_re [16];
    logic signed [9:0] rom16_im [16];
    logic signed [9:0] rom4_re [4];
    logic signed [9:0] rom4_im [4];

    assign tr0 = rom16_re[ta0];
    assign ti0 = rom16_im[ta0];
    assign tr1 = rom16_re[ta1];
    assign ti1 = rom16_im[ta1];
    assign tr2 = rom4_re[ta2];
    assign ti2 = rom4_im[ta2];

    sdf_r22_stage #(.M(16), .WIDTH(8), .TW_WIDTH(10), .SCALE(0)) dut0 (
        .clk(clk), .rst(rst), .enable_in(en), .in_re(in_re), .in_im(in_im),
        .tw_addr(ta0), .tw_re(tr0), .tw_im(ti0),
        .enable_out(eo0), .out_re(o0r), .out_im(o0i));

    sdf_r22_stage #(.M(16), .WIDTH(8), .TW_WIDTH(10), .SCALE(1)) dut1 (
        .clk(clk), .rst(rst), .enable_in(en), .in_re(in_re), .in_im(in_im),
        .tw_addr(ta1), .tw_re(tr1), .tw_im(ti1),
        .enable_out(eo1), .out_re(o1r), .out_im(o1i));

    sdf_r22_stage #(.M(4), .WIDTH(8), .TW_WIDTH(10), .SCALE(0)) dut2 (
        .clk(clk), .rst(rst), .enable_in(en), .in_re(in_re), .in_im(in_im),
        .tw_addr(ta2), .tw_re(tr2), .tw_im(ti2),
        .enable_out(eo2), .out_re(o2r), .out_im(o2i));

    typedef struct {
        int re;
        int im;
        int cyc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sbq [3][$];
    int   last_re [3];
    int   last_im [3];
    int   xr [$];
    int   xi [$];
    int   md_of [3] = '{16, 16, 4};
    int   sc_of [3] = '{0, 1, 0};

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int rnd(input real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    function automatic int bitrev2(input int s);
        if (s == 1) return 2;
        if (s == 2) return 1;
        return s;
    endfunction

    function automatic int rom_re(input int md, input int a);
        if (md == 16) return int'(rom16_re[a]);
        return int'(rom4_re[a]);
    endfunction

    function automatic int rom_im(input int md, input int a);
        if (md == 16) return int'(rom16_im[a]);
        return int'(rom4_im[a]);
    endfunction

    function automatic int sat(input int v, input int lim);
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic int model_addr(input int md, input int n);
        int q, p;
        q = md / 4;
        p = (n - 3 * q) % md;
        return ((p % q) * bitrev2(p / q)) % md;
    endfunction

    // y[p] = sum_l x[m+l*q] * (-j)^(l*k), optional /4, times W, round, saturate
    task automatic model_out(input int md, input int sc, input int n, output int yr, output int yi);
        int q, g, b, p, m, k, sr, si, vr, vi, cr, ci, pr, pq, a;
        q  = md / 4;
        g  = n - 3 * q;
        b  = g / md;
        p  = g % md;
        m  = p % q;
        k  = bitrev2(p / q);
        sr = 0;
        si = 0;
        for (int l = 0; l < 4; l++) begin
            vr = xr[b * md + m + l * q];
            vi = xi[b * md + m + l * q];
            case ((l * k) % 4)
                0: begin sr += vr; si += vi; end
                1: begin sr += vi; si -= vr; end
                2: begin sr -= vr; si -= vi; end
                default: begin sr -= vi; si += vr; end
            endcase
        end
        if (sc != 0) begin
            sr = (sr + 2) >>> 2;
            si = (si + 2) >>> 2;
        end
        a  = (m * k) % md;
        cr = rom_re(md, a);
        ci = rom_im(md, a);
        pr = (sr * cr - si * ci + 128) >>> 8;
        pq = (sr * ci + si * cr + 128) >>> 8;
        yr = sat(pr, (sc != 0) ? 128 : 512);
        yi = sat(pq, (sc != 0) ? 128 : 512);
    endtask

    task automatic check_dut(input int d, input logic eo, input int ore, input int oim);
        exp_t e;
        if (sbq[d].size() > 0 && sbq[d][0].cyc == cyc) begin
            e = sbq[d].pop_front();
            check_int($sformatf("d%0d enable_out cyc%0d", d, cyc), int'(eo), 1);
            check_int($sformatf("d%0d out_re cyc%0d", d, cyc), ore, e.re);
            check_int($sformatf("d%0d out_im cyc%0d", d, cyc), oim, e.im);
            last_re[d] = e.re;
            last_im[d] = e.im;
            $display("d%0d cyc %0d out (%0d,%0d) exp (%0d,%0d)", d, cyc, ore, oim, e.re, e.im);
        end else begin
            check_int($sformatf("d%0d idle enable_out cyc%0d", d, cyc), int'(eo), 0);
            check_int($sformatf("d%0d hold out_re cyc%0d", d, cyc), ore, last_re[d]);
            check_int($sformatf("d%0d hold out_im cyc%0d", d, cyc), oim, last_im[d]);
        end
    endtask

    // Output monitor, sampled just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            check_dut(0, eo0, int'($signed(o0r)), int'($signed(o0i)));
            check_dut(1, eo1, int'($signed(o1r)), int'($signed(o1i)));
            check_dut(2, eo2, int'($signed(o2r)), int'($signed(o2i)));
        end
    end

    task automatic push_strobe(input int re, input int im);
        int n, yr, yi;
        @(negedge clk);
        rst   = 1'b0;
        en    = 1'b1;
        in_re = 8'(re);
        in_im = 8'(im);
        xr.push_back(re);
        xi.push_back(im);
        n = xr.size() - 1;
        for (int d = 0; d < 3; d++) begin
            if (n >= 3 * md_of[d] / 4) begin
                model_out(md_of[d], sc_of[d], n, yr, yi);
                sbq[d].push_back('{yr, yi, cyc + 1});
            end
        end
        #1;
        if (n >= 12) begin
            check_int($sformatf("d0 tw_addr n%0d", n), int'(ta0), model_addr(16, n));
            check_int($sformatf("d1 tw_addr n%0d", n), int'(ta1), model_addr(16, n));
        end
        if (n >= 3) begin
            check_int($sformatf("d2 tw_addr n%0d", n), int'(ta2), model_addr(4, n));
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            rst   = 1'b0;
            en    = 1'b0;
            in_re = 8'($urandom_range(0, 255));
            in_im = 8'($urandom_range(0, 255));
        end
    endtask

    // Reset together with a strobe: that strobe and the partial block are discarded
    task automatic reset_with_strobe();
        @(negedge clk);
        rst   = 1'b1;
        en    = 1'b1;
        in_re = 8'($urandom_range(0, 255));
        in_im = 8'($urandom_range(0, 255));
        for (int d = 0; d < 3; d++) begin
            sbq[d].delete();
            last_re[d] = 0;
            last_im[d] = 0;
        end
        xr.delete();
        xi.delete();
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        in_re = 8'd0;
        in_im = 8'd0;
        for (int d = 0; d < 3; d++) begin
            last_re[d] = 0;
            last_im[d] = 0;
        end
        for (int a = 0; a < 16; a++) begin
            rom16_re[a] = 10'(rnd(256.0 * $cos(2.0 * 3.14159265358979 * a / 16.0)));
            rom16_im[a] = 10'(rnd(-256.0 * $sin(2.0 * 3.14159265358979 * a / 16.0)));
        end
        for (int a = 0; a < 4; a++) begin
            rom4_re[a] = 10'(rnd(256.0 * $cos(2.0 * 3.14159265358979 * a / 4.0)));
            rom4_im[a] = 10'(rnd(-256.0 * $sin(2.0 * 3.14159265358979 * a / 4.0)));
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Impulse
        for (int i = 0; i < 16; i++) push_strobe((i == 0) ? 100 : 0, 0);
        // DC
        for (int i = 0; i < 16; i++) push_strobe(50, 0);
        // Twiddle rounding
        for (int i = 0; i < 16; i++) push_strobe((i == 1) ? 64 : 0, 0);
        // Saturation
        for (int i = 0; i < 16; i++) begin
            case (i)
                1:       push_strobe(127, 127);
                5:       push_strobe(-127, 127);
                9:       push_strobe(-127, -127);
                13:      push_strobe(127, -127);
                default: push_strobe(0, 0);
            endcase
        end
        // Full-scale input, exercises divide-by-4 rounding
        for (int i = 0; i < 16; i++) push_strobe(127, 127);
        // Twiddle rounding again with random gaps
        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(0, 3));
            push_strobe((i == 1) ? 64 : 0, 0);
        end
        idle(3);
        // Partial block then reset coincident with strobe 7
        for (int i = 0; i < 7; i++) begin
            push_strobe(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        end
        reset_with_strobe();
        // Fresh block of random data, then zero flush
        for (int i = 0; i < 16; i++) begin
            push_strobe(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        end
        for (int i = 0; i < 12; i++) begin
            idle($urandom_range(0, 1));
            push_strobe(0, 0);
        end
        idle(4);
        for (int d = 0; d < 3; d++) begin
            check_int($sformatf("d%0d pending expectations", d), sbq[d].size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
